// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : inst_fetch_queue
// Desc   : MIPS fetch front end; up to DEPTH word fetches in flight, in-order
//          response queue, valid/ready hand-off to decode, redirect flush.
//          Define FETCH_HALT_ON_ZERO_EN to stop fetching on a zero word.
// Rev    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 30,
  parameter logic [ADDR_W-1:0] RESET_PC = 30'h0100000
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_inst,
  input  logic              out_ready,
  output logic              halted
);
  localparam int            c_pw    = $clog2(DEPTH);
  localparam int            c_cw    = c_pw + 1;
  localparam logic [c_cw:0] c_depth = (c_cw+1)'(DEPTH);

  logic [ADDR_W-1:0] r_fpc;
  logic [ADDR_W-1:0] r_rpc;
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [31:0]       r_inst_mem [DEPTH];
  logic [c_pw-1:0]   r_head;
  logic [c_pw-1:0]   r_tail;
  logic [c_cw-1:0]   r_count;
  logic [c_cw-1:0]   r_outst;
  logic [c_cw-1:0]   r_discard;
  logic [c_cw:0]     w_inflight;
  logic [c_cw-1:0]   w_outst_nx;
  logic              w_stop;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_zero_push;

  // Occupied slots plus in-flight fetches form the credit limit, so a response never overflows.
  assign w_inflight = {1'b0, r_count} + {1'b0, r_outst};
  assign imem_req   = reset_n && !redirect && !w_stop && (w_inflight < c_depth);
  assign imem_addr  = r_fpc;
  assign w_accept   = imem_req && imem_ready;
  assign w_push     = imem_rvalid && (r_discard == '0) && !redirect;
  assign out_valid  = (r_count != '0);
  assign w_pop      = out_valid && out_ready && !redirect;
  assign w_outst_nx = r_outst + c_cw'(w_accept) - c_cw'(imem_rvalid);
  assign out_pc     = out_valid ? r_pc_mem[r_head]   : '0;
  assign out_inst   = out_valid ? r_inst_mem[r_head] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fpc     <= RESET_PC;
      r_rpc     <= RESET_PC;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_outst   <= '0;
      r_discard <= '0;
    end else if (redirect) begin
      // Everything still in flight belongs to the old stream and must be dropped.
      r_fpc     <= redirect_pc;
      r_rpc     <= redirect_pc;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_outst   <= w_outst_nx;
      r_discard <= w_outst_nx;
    end else begin
      if (w_accept) r_fpc <= r_fpc + ADDR_W'(1);
      if (w_push) begin
        r_rpc  <= r_rpc + ADDR_W'(1);
        r_tail <= r_tail + c_pw'(1);
      end
      if (w_pop) r_head <= r_head + c_pw'(1);
      r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
      r_outst <= w_outst_nx;
      if (imem_rvalid && (r_discard != '0)) r_discard <= r_discard - c_cw'(1);
      else if (w_zero_push)                 r_discard <= w_outst_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]   <= r_rpc;
      r_inst_mem[r_tail] <= imem_rdata;
    end
  end

`ifdef FETCH_HALT_ON_ZERO_EN
  logic r_stop;
  logic r_halted;

  assign w_stop      = r_stop;
  assign halted      = r_halted;
  assign w_zero_push = w_push && (imem_rdata == 32'h0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stop   <= 1'b0;
      r_halted <= 1'b0;
    end else if (redirect) begin
      r_stop   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      if (w_zero_push) r_stop <= 1'b1;
      // Once stopped, the only zero word left to pop is the one that stopped fetch.
      if (w_pop && r_stop && (r_inst_mem[r_head] == 32'h0)) r_halted <= 1'b1;
    end
  end
`else
  assign w_stop      = 1'b0;
  assign halted      = 1'b0;
  assign w_zero_push = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_inst_fetch_queue
// Desc   : Randomized bench for inst_fetch_queue against a queue-based model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [29:0] RESET_PC = 30'h0100000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [29:0] redirect_pc;
  logic        out_valid;
  logic [29:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic        halted;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(30), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ready(out_ready), .halted(halted)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory image; every 32nd word is a zero (nop) word.
  function automatic logic [31:0] img(input logic [29:0] a);
    if (a[4:0] == 5'h13) return 32'h0;
    return ({2'b00, a} * 32'h9E3779B1) ^ 32'hA5000001;
  endfunction

  function automatic logic [29:0] pick_pc();
    if ($urandom_range(0, 3) == 0) return 30'h3FFFFFFC + 30'($urandom_range(0, 3));
    return RESET_PC + 30'($urandom_range(0, 255));
  endfunction

  // Reference model: decode queue of PCs, in-flight fetches tagged stale or live.
  logic [29:0] m_q[$];
  logic [29:0] m_fl_pc[$];
  bit          m_fl_st[$];
  logic [29:0] m_fpc;
  bit          m_stop;
  bit          m_halted;

  // Memory environment: in-order responses, each ready at a given cycle.
  logic [29:0] mem_addr[$];
  int          mem_rdy[$];
  int          last_rdy;
  int          cyc;

  int          p_ready, p_oready, p_redir, lat_lo, lat_hi;
  bit          force_redir;
  logic [29:0] force_pc;
  bit          watch;
  logic [29:0] watch_pc;
  int          n_acc;

  task automatic model_reset();
    m_q.delete(); m_fl_pc.delete(); m_fl_st.delete();
    m_fpc = RESET_PC; m_stop = 0; m_halted = 0;
    mem_addr.delete(); mem_rdy.delete(); last_rdy = 0;
  endtask

  task automatic step();
    bit          exp_req, acc, st, zs, s_req;
    logic [29:0] s_addr, pc;
    int          rdy;
    redirect = 1'b0;
    redirect_pc = 30'($urandom);
    if (force_redir) begin
      redirect = 1'b1; redirect_pc = force_pc; force_redir = 0;
      watch = 1; watch_pc = force_pc;
    end else if ($urandom_range(0, 99) < p_redir) begin
      redirect = 1'b1; redirect_pc = pick_pc();
    end
    imem_ready  = ($urandom_range(0, 99) < p_ready);
    out_ready   = ($urandom_range(0, 99) < p_oready);
    imem_rvalid = (mem_addr.size() > 0) && (mem_rdy[0] <= cyc);
    imem_rdata  = imem_rvalid ? img(mem_addr[0]) : $urandom;
    #3;
    exp_req = !redirect && !m_stop && (m_q.size() + m_fl_pc.size() < DEPTH);
    check("imem_req", 64'(imem_req), 64'(exp_req));
    if (exp_req) check("imem_addr", 64'(imem_addr), 64'(m_fpc));
    check("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("out_pc", 64'(out_pc), 64'(m_q[0]));
      check("out_inst", 64'(out_inst), 64'(img(m_q[0])));
    end
    check("halted", 64'(halted), 64'(m_halted));
    if (watch && !redirect && out_valid) begin
      check("first_pc", 64'(out_pc), 64'(watch_pc));
      watch = 0;
    end
    s_req = imem_req; s_addr = imem_addr;
    if (s_req && imem_ready) n_acc++;
    @(posedge clk);
    acc = exp_req && imem_ready;
    zs  = 0;
    if (redirect) begin
      if (imem_rvalid && m_fl_pc.size() > 0) begin
        void'(m_fl_pc.pop_front()); void'(m_fl_st.pop_front());
      end
      foreach (m_fl_st[i]) m_fl_st[i] = 1'b1;
      m_q.delete(); m_fpc = redirect_pc; m_stop = 0; m_halted = 0;
    end else begin
      if (m_q.size() > 0 && out_ready) begin
        pc = m_q.pop_front();
`ifdef FETCH_HALT_ON_ZERO_EN
        if (m_stop && img(pc) == 32'h0) m_halted = 1;
`endif
      end
      if (imem_rvalid && m_fl_pc.size() > 0) begin
        pc = m_fl_pc.pop_front(); st = m_fl_st.pop_front();
        if (!st) begin
          m_q.push_back(pc);
`ifdef FETCH_HALT_ON_ZERO_EN
          if (img(pc) == 32'h0) begin
            m_stop = 1; zs = 1;
            foreach (m_fl_st[i]) m_fl_st[i] = 1'b1;
          end
`endif
        end
      end
      if (acc) begin
        m_fl_pc.push_back(m_fpc); m_fl_st.push_back(zs);
        m_fpc = m_fpc + 30'd1;
      end
    end
    if (imem_rvalid) begin void'(mem_addr.pop_front()); void'(mem_rdy.pop_front()); end
    if (s_req && imem_ready) begin
      rdy = cyc + int'($urandom_range(lat_lo, lat_hi));
      if (rdy < last_rdy) rdy = last_rdy;
      mem_addr.push_back(s_addr); mem_rdy.push_back(rdy); last_rdy = rdy;
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic knobs(input int pr, input int po, input int pd, input int llo, input int lhi);
    p_ready = pr; p_oready = po; p_redir = pd; lat_lo = llo; lat_hi = lhi;
  endtask

  task automatic check_reset_outputs();
    check("rst_req", 64'(imem_req), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_pc", 64'(out_pc), 64'(0));
    check("rst_inst", 64'(out_inst), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
  endtask

  initial begin
    reset_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    force_redir = 0; force_pc = '0; watch = 0; watch_pc = '0; n_acc = 0; cyc = 0;
    model_reset();
    #2;
    check_reset_outputs();
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    // Streaming, one instruction per cycle.
    knobs(100, 100, 0, 1, 1);
    run(30);

    // Drain, then stall decode: exactly DEPTH fetches accepted.
    knobs(0, 100, 0, 1, 1);
    run(8);
    n_acc = 0;
    knobs(100, 0, 0, 1, 1);
    run(12);
    check("stall_accepts", 64'(n_acc), 64'(DEPTH));
    knobs(100, 100, 0, 1, 1);
    run(10);

    // Latency 3 with fetches outstanding, then redirect.
    knobs(100, 100, 0, 3, 3);
    run(10);
    force_redir = 1; force_pc = RESET_PC + 30'h40;
    run(15);
    check("first_pc_seen", 64'(watch), 64'(0));

    // Random traffic with redirects, including around the address wrap.
    knobs(70, 70, 6, 1, 4);
    run(1500);

    // Build backlog, then async reset mid-cycle.
    knobs(100, 0, 0, 3, 3);
    run(6);
    #2 reset_n = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1;
    check("post_rst_req", 64'(imem_req), 64'(1));
    check("post_rst_addr", 64'(imem_addr), 64'(RESET_PC));
    @(posedge clk); #1;

    knobs(80, 60, 4, 1, 3);
    run(800);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
